float_to_fixed: RTL and testbench

//   Converts one IEEE-754 single-precision value per cycle into a signed two's-complement

---
 rtl/float_to_fixed.sv | 114 +++++++++++
 tb/tb_float_to_fixed.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed.sv
// IEEE-754 single to signed Q(32-FRAC_BITS).FRAC_BITS converter, one registered stage.
// Define FTF_ROUND_EN for round-half-away-from-zero; the default build truncates toward zero.
module float_to_fixed #(
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] float,
    output logic        out_valid,
    output logic [31:0] fixed,
    output logic        ovf
);

    localparam int unsigned SIG_W = 24;
    localparam int unsigned MAG_W = 33;
    localparam int unsigned SH_W  = 10;
    localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_MAX = 32'h8000_0000;

    logic                    w_sign;
    logic [7:0]              w_exp;
    logic [22:0]             w_man;
    logic [SIG_W-1:0]        w_sig;
    logic signed [SH_W-1:0]  w_sh;
    logic [SH_W-1:0]         w_rs;
    logic [MAG_W-1:0]        w_mag_t;
    logic [MAG_W-1:0]        w_mag;
    logic                    w_big;
    logic                    w_rnd;
    logic [31:0]             w_fixed;
    logic                    w_ovf;

    logic                    r_out_valid;
    logic [31:0]             r_fixed;
    logic                    r_ovf;

    // Align the significand: left shifts past 8 always exceed 32 bits, so only flag them.
    always_comb begin
        w_sign  = float[31];
        w_exp   = float[30:23];
        w_man   = float[22:0];
        w_sig   = {1'b1, w_man};
        w_sh    = $signed({2'b00, w_exp}) - $signed(10'd150) + $signed(SH_W'(FRAC_BITS));
        w_rs    = SH_W'(-w_sh);
        w_mag_t = '0;
        w_big   = 1'b0;
        w_rnd   = 1'b0;
        if (!w_sh[SH_W-1]) begin
            if (w_sh > 10'sd8) begin
                w_big = 1'b1;
            end else begin
                w_mag_t = MAG_W'(w_sig) << w_sh[3:0];
            end
        end else if (w_rs < 10'd24) begin
            w_mag_t = MAG_W'(w_sig >> w_rs[4:0]);
        end
`ifdef FTF_ROUND_EN
        // Most significant discarded bit decides the round-up; beyond 24 it is always 0.
        if (w_sh[SH_W-1] && (w_rs <= 10'd24)) begin
            w_rnd = w_sig[5'(w_rs - 10'd1)];
        end
`endif
        w_mag = w_mag_t + MAG_W'(w_rnd);
    end

    // Classify, saturate and negate.
    always_comb begin
        w_fixed = '0;
        w_ovf   = 1'b0;
        if (w_exp == 8'h00) begin
            w_fixed = '0;
        end else if (w_exp == 8'hFF) begin
            w_ovf = 1'b1;
            if (w_man == 23'd0) begin
                w_fixed = w_sign ? NEG_MAX : POS_MAX;
            end
        end else if (!w_sign) begin
            if (w_big || (w_mag > MAG_W'(POS_MAX))) begin
                w_fixed = POS_MAX;
                w_ovf   = 1'b1;
            end else begin
                w_fixed = w_mag[31:0];
            end
        end else begin
            if (w_big || (w_mag > MAG_W'(NEG_MAX))) begin
                w_fixed = NEG_MAX;
                w_ovf   = 1'b1;
            end else begin
                w_fixed = -w_mag[31:0];
            end
        end
    end

    // Output stage: results load only on valid input, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_fixed     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_fixed <= w_fixed;
                r_ovf   <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign fixed     = r_fixed;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_float_to_fixed.sv
// Randomized bench for float_to_fixed against a real-arithmetic reference model.
// Follows FTF_ROUND_EN the same way the RTL does.
module tb_float_to_fixed;

    localparam int unsigned FRAC = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] float_in;
    logic        out_valid;
    logic [31:0] fixed_out;
    logic        ovf_out;

    int          n_checks;
    int          n_fails;
    logic [31:0] exp_fixed;
    logic        exp_ovf;

    float_to_fixed #(.FRAC_BITS(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .float     (float_in),
        .out_valid (out_valid),
        .fixed     (fixed_out),
        .ovf       (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Value = sig * 2^(e-150+FRAC) evaluated in double precision (exact here).
    function automatic void ref_model(input logic [31:0] f, output logic [31:0] fx, output logic o);
        logic        s;
        int          e;
        logic [22:0] m;
        real         x;
        real         lim;
        longint      v;
        s = f[31];
        e = int'(f[30:23]);
        m = f[22:0];
        fx = 32'd0;
        o  = 1'b0;
        if (e == 255) begin
            o  = 1'b1;
            fx = (m != 23'd0) ? 32'd0 : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
        end else if (e != 0) begin
            x = real'(int'({1'b1, m})) * $pow(2.0, real'(e - 150 + int'(FRAC)));
`ifdef FTF_ROUND_EN
            x = $floor(x + 0.5);
`else
            x = $floor(x);
`endif
            lim = s ? 2147483648.0 : 2147483647.0;
            if (x > lim) begin
                o  = 1'b1;
                fx = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                v  = longint'(x);
                if (s) v = -v;
                fx = v[31:0];
            end
        end
    endfunction

    task automatic apply(input logic [31:0] f, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        float_in = f;
        ref_model(f, exp_fixed, exp_ovf);
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, ".fixed"}, fixed_out, exp_fixed);
        check_eq({tag, ".ovf"},   {31'd0, ovf_out}, {31'd0, exp_ovf});
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        float_in = $urandom();
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ".hold"},  fixed_out, exp_fixed);
        check_eq({tag, ".hovf"},  {31'd0, ovf_out}, {31'd0, exp_ovf});
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          sel;
        f   = $urandom();
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       ;
            1:       f[30:23] = 8'h00;
            2:       f[30:23] = 8'hFF;
            3: begin
                f[30:23] = 8'd142;
                if ($urandom_range(0, 1) == 1) f[22:0] = 23'd0;
            end
            default: f[30:23] = 8'($urandom_range(100, 150));
        endcase
        return f;
    endfunction

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        exp_fixed = 32'd0;
        exp_ovf   = 1'b0;
        in_valid  = 1'b0;
        float_in  = 32'd0;
        rst_n     = 1'b0;
        #3;
        check_eq("rst.valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.fixed", fixed_out, 32'd0);
        check_eq("rst.ovf",   {31'd0, ovf_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed points, including saturation and rounding boundaries.
        apply(32'h4078_0000, "t1_3p875");
        apply(32'hC078_0000, "t2_m3p875");
        apply(32'h3F80_0000, "t2_one");
        apply(32'h8000_0000, "t2_negzero");
        apply(32'h4700_0000, "t3_p32768");
        apply(32'hC700_0000, "t3_m32768");
        apply(32'hFF80_0000, "t3_minf");
        apply(32'h7F80_0000, "t3_pinf");
        apply(32'h3780_0000, "t4_2m16");
        apply(32'h3700_0000, "t4_2m17");
        apply(32'hB700_0000, "t4_m2m17");
        apply(32'h3640_0000, "t4_tiny");
        apply(32'h46FF_FFFF, "t3_justbelow");
        apply(32'h7FC0_0000, "t5_nan");
        apply(32'h0000_0001, "t5_denorm");
        apply(32'hC780_0000, "t3_m65536");
        for (int i = 0; i < 3; i++) idle("t5_idle");

        // Reset mid-stream clears outputs without a clock edge.
        apply(32'h4078_0000, "t6_pre0");
        apply(32'hC078_0000, "t6_pre1");
        @(negedge clk);
        float_in = 32'h3F80_0000;
        #2;
        rst_n = 1'b0;
        #1;
        exp_fixed = 32'd0;
        exp_ovf   = 1'b0;
        check_eq("t6_rst.valid", {31'd0, out_valid}, 32'd0);
        check_eq("t6_rst.fixed", fixed_out, 32'd0);
        check_eq("t6_rst.ovf",   {31'd0, ovf_out}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("t6_inrst.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        apply(32'h4078_0000, "t6_resume");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle("rnd_idle");
            else apply(rand_float(), "rnd");
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
